// File: rtl/pipe_req_arbiter_pkg.sv
// Shared types and constants for the pipeline-input round-robin arbiter
// and the async stage benches that feed it.
package pipe_arb_pkg;

    localparam int PIPE_ARB_DW = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ_HI  = 2'd1,
        REQ_LO  = 2'd2,
        RELEASE = 2'd3
    } arb_state_e;

    // Successor of a requester index, wrapping at n-1 back to 0.
    function automatic int rr_next(input int idx, input int n);
        return ((idx + 32'sd1) >= n) ? 32'sd0 : (idx + 32'sd1);
    endfunction

endpackage

// File: rtl/pipe_req_arbiter_if.sv
// Requester-side and stage-side handshake bundle of pipe_req_arbiter.
// slave = arbiter view, master = producer/stage (bench) view.
interface pipe_req_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int DW    = pipe_arb_pkg::PIPE_ARB_DW
);
    localparam int IDW = $clog2(N_REQ);

    logic [N_REQ-1:0]    req_in;
    logic [N_REQ*DW-1:0] data_in;
    logic [N_REQ-1:0]    ack_out;
    logic                req_out;
    logic [DW-1:0]       data_out;
    logic                ack_in;
    logic [IDW-1:0]      grant_id;
    logic                busy;

    modport slave (
        input  req_in, data_in, ack_in,
        output ack_out, req_out, data_out, grant_id, busy
    );

    modport master (
        output req_in, data_in, ack_in,
        input  ack_out, req_out, data_out, grant_id, busy
    );

endinterface

// File: rtl/pipe_req_arbiter_rr_pick.sv
// Combinational round-robin first-one search over a candidate vector,
// starting at ptr and wrapping at N_REQ-1 -> 0.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] cand,
    input  logic [IDW-1:0]   ptr,
    output logic             valid,
    output logic [IDW-1:0]   idx
);

    int             sum_s;
    logic [IDW-1:0] pos_s;

    // Walk ptr, ptr+1, ... and keep the first candidate found.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        sum_s = 32'sd0;
        pos_s = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum_s = int'(ptr) + k;
            if (sum_s >= N_REQ) begin
                sum_s = sum_s - N_REQ;
            end else begin
                sum_s = sum_s;
            end
            pos_s = IDW'(sum_s);
            if (!valid && cand[pos_s]) begin
                valid = 1'b1;
                idx   = pos_s;
            end else begin
                idx   = idx;
            end
        end
    end

endmodule

// File: rtl/pipe_req_arbiter.sv
// Round-robin arbiter driving one async pipeline stage input with a full
// 4-phase cycle per transfer. Optional macro PIPE_ARB_ACK_SYNC_EN adds a
// 2-flop synchroniser on the stage ack.
module pipe_req_arbiter
    import pipe_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DW    = PIPE_ARB_DW
) (
    input  logic              clk,
    input  logic              rst,
    pipe_req_arbiter_if.slave bus
);

    localparam int IDW = $clog2(N_REQ);

    logic ack_s;

`ifdef PIPE_ARB_ACK_SYNC_EN
    logic ack_meta_r;
    logic ack_sync_r;

    // Two-flop synchroniser for the stage ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_meta_r <= 1'b0;
            ack_sync_r <= 1'b0;
        end else begin
            ack_meta_r <= bus.ack_in;
            ack_sync_r <= ack_meta_r;
        end
    end

    assign ack_s = ack_sync_r;
`else
    assign ack_s = bus.ack_in;
`endif

    arb_state_e       state_r, state_nx_s;
    logic [IDW-1:0]   ptr_r, ptr_nx_s;
    logic [IDW-1:0]   grant_id_r, grant_id_nx_s;
    logic [IDW-1:0]   pick_idx_s;
    logic             pick_valid_s;
    logic             req_out_r, req_out_nx_s;
    logic             busy_r;
    logic [DW-1:0]    data_out_r, data_out_nx_s, data_sel_s;
    logic [N_REQ-1:0] ack_out_r, ack_out_nx_s, cand_s;

    // A requester still holding req after its ack is not a new candidate.
    assign cand_s = bus.req_in & ~ack_out_r;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_pick (
        .cand  (cand_s),
        .ptr   (ptr_r),
        .valid (pick_valid_s),
        .idx   (pick_idx_s)
    );

    // Mux the winner's data word out of the flattened requester bus.
    always_comb begin
        data_sel_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx_s == IDW'(i)) begin
                data_sel_s = bus.data_in[i*DW +: DW];
            end else begin
                data_sel_s = data_sel_s;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE:    state_nx_s = pick_valid_s            ? REQ_HI : IDLE;
            REQ_HI:  state_nx_s = ack_s                   ? REQ_LO : REQ_HI;
            REQ_LO:  state_nx_s = !ack_s                  ? RELEASE : REQ_LO;
            RELEASE: state_nx_s = !bus.req_in[grant_id_r] ? IDLE : RELEASE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Next values of the registered outputs and the round-robin pointer.
    always_comb begin
        req_out_nx_s  = req_out_r;
        data_out_nx_s = data_out_r;
        grant_id_nx_s = grant_id_r;
        ack_out_nx_s  = ack_out_r;
        ptr_nx_s      = ptr_r;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    grant_id_nx_s = pick_idx_s;
                    data_out_nx_s = data_sel_s;
                    req_out_nx_s  = 1'b1;
                end else begin
                    req_out_nx_s  = 1'b0;
                end
            end
            REQ_HI: begin
                if (ack_s) begin
                    req_out_nx_s = 1'b0;
                end else begin
                    req_out_nx_s = 1'b1;
                end
            end
            REQ_LO: begin
                if (!ack_s) begin
                    ack_out_nx_s[grant_id_r] = 1'b1;
                end else begin
                    ack_out_nx_s = ack_out_r;
                end
            end
            RELEASE: begin
                // The winner drops to lowest priority for the next round.
                if (!bus.req_in[grant_id_r]) begin
                    ack_out_nx_s[grant_id_r] = 1'b0;
                    ptr_nx_s = IDW'(rr_next(int'(grant_id_r), N_REQ));
                end else begin
                    ptr_nx_s = ptr_r;
                end
            end
            default: begin
                req_out_nx_s = 1'b0;
                ack_out_nx_s = '0;
            end
        endcase
    end

    // Output and pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_out_r  <= 1'b0;
            data_out_r <= '0;
            grant_id_r <= '0;
            ack_out_r  <= '0;
            ptr_r      <= '0;
            busy_r     <= 1'b0;
        end else begin
            req_out_r  <= req_out_nx_s;
            data_out_r <= data_out_nx_s;
            grant_id_r <= grant_id_nx_s;
            ack_out_r  <= ack_out_nx_s;
            ptr_r      <= ptr_nx_s;
            busy_r     <= (state_nx_s != IDLE);
        end
    end

    assign bus.req_out  = req_out_r;
    assign bus.data_out = data_out_r;
    assign bus.grant_id = grant_id_r;
    assign bus.ack_out  = ack_out_r;
    assign bus.busy     = busy_r;

endmodule

// File: tb/tb_pipe_req_arbiter.sv
// Directed bench for pipe_req_arbiter: cycle vector table (direct ack path)
// plus hand sequences for contention and the synchronised-ack build.
module tb_pipe_req_arbiter;

    localparam int N = 4;
    localparam int W = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipe_req_arbiter_if #(.N_REQ(N), .DW(W)) bus ();

    pipe_req_arbiter #(.N_REQ(N), .DW(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       ack;
        logic       ro;
        logic [3:0] ao;
        logic [1:0] gid;
        logic       busy;
        logic [2:0] dout;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic [3:0] rq, input logic a,
                       input logic ro, input logic [3:0] ao, input logic [1:0] g,
                       input logic b, input logic [2:0] d);
        vec_t v;
        v.rst = r; v.req = rq; v.ack = a; v.ro = ro;
        v.ao = ao; v.gid = g; v.busy = b; v.dout = d;
        vt.push_back(v);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int order[6];
        logic [2:0] dv[4];
        int grants;
        int overlap;
        int lat;
        logic prev_ro;

        order = '{0, 1, 3, 0, 1, 3};
        dv    = '{3'd1, 3'd2, 3'd5, 3'd7};

        rst         = 1'b1;
        bus.req_in  = 4'b0000;
        bus.ack_in  = 1'b0;
        bus.data_in = {3'd7, 3'd5, 3'd2, 3'd1};

`ifndef PIPE_ARB_ACK_SYNC_EN
        //  rst   req      ack   req_out ack_out  gid   busy  data_out
        add(1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 3'd0);
        add(1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 3'd0);
        add(1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 3'd0);
        // stage ack high while idle must not start anything
        add(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 3'd0);
        add(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 3'd0);
        // single transfer from requester 2
        add(1'b0, 4'b0100, 1'b0, 1'b1, 4'b0000, 2'd2, 1'b1, 3'd5);
        add(1'b0, 4'b0100, 1'b0, 1'b1, 4'b0000, 2'd2, 1'b1, 3'd5);
        add(1'b0, 4'b0100, 1'b1, 1'b0, 4'b0000, 2'd2, 1'b1, 3'd5);
        add(1'b0, 4'b0100, 1'b1, 1'b0, 4'b0000, 2'd2, 1'b1, 3'd5);
        add(1'b0, 4'b0100, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1, 3'd5);
        add(1'b0, 4'b0100, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1, 3'd5);
        add(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b0, 3'd5);
        // wrap: ptr=3, only requester 0
        add(1'b0, 4'b0001, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b1, 3'd1);
        add(1'b0, 4'b0001, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b1, 3'd1);
        add(1'b0, 4'b0001, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1, 3'd1);
        add(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 3'd1);
        // ptr=1 now: requester 1 beats requester 0
        add(1'b0, 4'b0011, 1'b0, 1'b1, 4'b0000, 2'd1, 1'b1, 3'd2);
        add(1'b0, 4'b0011, 1'b1, 1'b0, 4'b0000, 2'd1, 1'b1, 3'd2);
        add(1'b0, 4'b0011, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b1, 3'd2);
        add(1'b0, 4'b0001, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b0, 3'd2);
        add(1'b0, 4'b0001, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b1, 3'd1);
        // reset in REQ_HI aborts, then pending request 0 is re-granted
        add(1'b1, 4'b0001, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 3'd0);
        add(1'b0, 4'b0001, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b1, 3'd1);
        add(1'b0, 4'b0001, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b1, 3'd1);
        add(1'b0, 4'b0001, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1, 3'd1);
        add(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 3'd1);

        for (int i = 0; i < vt.size(); i++) begin
            rst        = vt[i].rst;
            bus.req_in = vt[i].req;
            bus.ack_in = vt[i].ack;
            tick();
            chk($sformatf("v%0d_req_out", i), int'(bus.req_out), int'(vt[i].ro));
            chk($sformatf("v%0d_ack_out", i), int'(bus.ack_out), int'(vt[i].ao));
            chk($sformatf("v%0d_grant_id", i), int'(bus.grant_id), int'(vt[i].gid));
            chk($sformatf("v%0d_busy", i), int'(bus.busy), int'(vt[i].busy));
            chk($sformatf("v%0d_data_out", i), int'(bus.data_out), int'(vt[i].dout));
        end
`else
        // synchronised ack: latency from ack_in rise to req_out fall
        bus.req_in = 4'b0000;
        tick();
        rst = 1'b0;
        bus.req_in = 4'b0100;
        tick();
        chk("sync_req_out_rise", int'(bus.req_out), 1);
        chk("sync_data_out", int'(bus.data_out), 5);
        bus.ack_in = 1'b1;
        lat = 0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            tick();
            if (!bus.req_out) lat = k;
        end
        chk("sync_ack_latency", lat, 3);
        bus.ack_in = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            tick();
            if (bus.ack_out[2]) lat = k;
        end
        chk("sync_ack_fall_latency", lat, 3);
        bus.req_in = 4'b0000;
        tick();
        chk("sync_release_ack_out", int'(bus.ack_out), 0);
        chk("sync_release_busy", int'(bus.busy), 0);
        // one-cycle glitch on ack_in while idle
        bus.ack_in = 1'b1;
        tick();
        bus.ack_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("sync_glitch_req_out", int'(bus.req_out), 0);
            chk("sync_glitch_busy", int'(bus.busy), 0);
        end
`endif

        // contention: requesters 0,1,3 re-request as soon as they are released
        rst        = 1'b1;
        bus.req_in = 4'b0000;
        bus.ack_in = 1'b0;
        tick();
        rst        = 1'b0;
        bus.req_in = 4'b1011;
        prev_ro    = 1'b0;
        grants     = 0;
        overlap    = 0;
        for (int cyc = 0; cyc < 400 && grants < 6; cyc++) begin
            tick();
            if ($countones(bus.ack_out) > 1) overlap++;
            if (bus.req_out && !prev_ro) begin
                chk($sformatf("cont_gid%0d", grants), int'(bus.grant_id), order[grants]);
                chk($sformatf("cont_data%0d", grants), int'(bus.data_out), int'(dv[order[grants]]));
                grants++;
            end
            prev_ro    = bus.req_out;
            bus.ack_in = bus.req_out;
            bus.req_in = 4'b1011 & ~bus.ack_out;
        end
        chk("cont_grant_count", grants, 6);
        chk("cont_ack_overlap", overlap, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
